instr_loader: RTL and testbench

- Instruction-side counterpart of the 8-bit microprocessor: it produces the INSTR byte that the core consumes for each PC value.
- Holds a small program RAM that is filled byte-by-byte over a valid/ready load interface.
- Holds the core in reset (CPU_HOLD) while loading, then serves instructions combinationally from the PC.
- Sits between the board input logic (switches/buttons or a serial front end) and the processor's INSTR/PC pins.

---
 rtl/instr_loader_if.sv | 27 ++
 rtl/instr_loader.sv | 182 ++++++++++++++++++
 tb/tb_instr_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Load-side and processor-side signals of the instruction loader.
// master = board/processor side, slave = the loader itself.
interface instr_loader_if #(
    parameter int AW = 4
);
    logic          LOAD_START;
    logic          LOAD_VALID;
    logic [7:0]    LOAD_DATA;
    logic          LOAD_LAST;
    logic          LOAD_READY;
    logic [7:0]    PC;
    logic [7:0]    INSTR;
    logic          CPU_HOLD;
    logic [AW:0]   PROG_LEN;
    logic          RUNNING;
    logic          ERR;

    modport master (
        output LOAD_START, LOAD_VALID, LOAD_DATA, LOAD_LAST, PC,
        input  LOAD_READY, INSTR, CPU_HOLD, PROG_LEN, RUNNING, ERR
    );

    modport slave (
        input  LOAD_START, LOAD_VALID, LOAD_DATA, LOAD_LAST, PC,
        output LOAD_READY, INSTR, CPU_HOLD, PROG_LEN, RUNNING, ERR
    );
endinterface

// File: rtl/instr_loader.sv
// Program RAM loader for the 8-bit core: clears RAM, takes a byte stream, then serves INSTR from PC.
// INSTR is combinational from PC; a byte is accepted only while LOAD_READY (LOAD state).
// Optional INSTR_LOADER_CHECKSUM_EN: final byte is a checksum, mismatch raises ERR and keeps the core held.
module instr_loader #(
    parameter int         DEPTH = 16,
    parameter int         AW    = 4,
    parameter logic [7:0] FILL  = 8'h00
) (
    input  logic           CLK,
    input  logic           RST,
    instr_loader_if.slave  bus
);
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_RUN} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   LEN_ONE  = 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   cptr_q, cptr_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW:0]     prog_len_q, prog_len_d;
    logic            pend_q, pend_d;
    logic            cpu_hold_q, cpu_hold_d;

    logic [7:0]      mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [7:0]      mem_wdata;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
    logic            err_q, err_d;
    logic [7:0]      sum_chk;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_CLEAR;
            cptr_q     <= '0;
            wptr_q     <= '0;
            prog_len_q <= '0;
            pend_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cptr_q     <= cptr_d;
            wptr_q     <= wptr_d;
            prog_len_q <= prog_len_d;
            pend_q     <= pend_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sum_q <= 8'h00;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
`endif

    // RAM content survives reset; CLEAR sweeps it back to FILL.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        cptr_d     = cptr_q;
        wptr_d     = wptr_q;
        prog_len_d = prog_len_q;
        pend_d     = pend_q;
        mem_we     = 1'b0;
        mem_waddr  = wptr_q;
        mem_wdata  = bus.LOAD_DATA;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = bus.LOAD_START ? 1'b0 : err_q;
        sum_chk    = sum_q + bus.LOAD_DATA;
`endif
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cptr_q;
                mem_wdata = FILL;
                cptr_d    = cptr_q + PTR_ONE;
                if (bus.LOAD_START) begin
                    pend_d = 1'b1;
                end
                if (cptr_q == LAST_IDX) begin
                    cptr_d     = '0;
                    pend_d     = 1'b0;
                    wptr_d     = '0;
                    prog_len_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                    state_d    = (pend_q || bus.LOAD_START) ? S_LOAD : S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.LOAD_START) begin
                    state_d    = S_LOAD;
                    wptr_d     = '0;
                    prog_len_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                end
            end
            S_LOAD: begin
                // A restart outranks a byte offered in the same cycle.
                if (bus.LOAD_START) begin
                    state_d    = S_CLEAR;
                    pend_d     = 1'b1;
                    cptr_d     = '0;
                    wptr_d     = '0;
                    prog_len_d = '0;
                end else if (bus.LOAD_VALID) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    if (bus.LOAD_LAST) begin
                        state_d = (sum_chk == 8'h00) ? S_RUN : S_IDLE;
                        err_d   = (sum_chk != 8'h00);
                    end else begin
                        mem_we     = 1'b1;
                        wptr_d     = wptr_q + PTR_ONE;
                        prog_len_d = prog_len_q + LEN_ONE;
                        sum_d      = sum_chk;
                        if (wptr_q == LAST_IDX) begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end
`else
                    mem_we     = 1'b1;
                    wptr_d     = wptr_q + PTR_ONE;
                    prog_len_d = prog_len_q + LEN_ONE;
                    if (bus.LOAD_LAST || (wptr_q == LAST_IDX)) begin
                        state_d = S_RUN;
                    end
`endif
                end
            end
            S_RUN: begin
                if (bus.LOAD_START) begin
                    state_d    = S_CLEAR;
                    pend_d     = 1'b1;
                    cptr_d     = '0;
                    wptr_d     = '0;
                    prog_len_d = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
        cpu_hold_d = (state_d != S_RUN);
    end

    always_comb begin
        bus.LOAD_READY = (state_q == S_LOAD);
        bus.RUNNING    = (state_q == S_RUN);
        bus.CPU_HOLD   = cpu_hold_q;
        bus.PROG_LEN   = prog_len_q;
        // 9-bit unsigned compare so PROG_LEN == 256 is representable.
        if ((state_q == S_RUN) && ({1'b0, bus.PC} < 9'(prog_len_q))) begin
            bus.INSTR = mem_q[bus.PC[AW-1:0]];
        end else begin
            bus.INSTR = FILL;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        bus.ERR = err_q;
`else
        bus.ERR = 1'b0;
`endif
    end
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: queue-based program model checked every cycle, plus directed literal checks.
module tb_instr_loader;
    localparam int DEPTH = 16;
    localparam int M_CLEAR = 0, M_IDLE = 1, M_LOAD = 2, M_RUN = 3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    instr_loader_if #(.AW(4)) bus();
    instr_loader #(.DEPTH(DEPTH), .AW(4), .FILL(8'h00)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model: phase, remaining clear cycles, pending start, stored program bytes.
    int          m_mode = M_CLEAR;
    int          m_left = DEPTH;
    bit          m_pend = 1'b0;
    bit          m_err  = 1'b0;
    byte unsigned prog[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_instr(input int pc);
        if (m_mode == M_RUN && pc < prog.size()) return int'(prog[pc]);
        return 0;
    endfunction

    always @(posedge CLK or negedge RST) begin : model
        int s;
        if (!RST) begin
            m_mode = M_CLEAR; m_left = DEPTH; m_pend = 1'b0; m_err = 1'b0;
            prog.delete();
        end else begin
            if (bus.LOAD_START) m_err = 1'b0;
            case (m_mode)
                M_CLEAR: begin
                    if (bus.LOAD_START) m_pend = 1'b1;
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = m_pend ? M_LOAD : M_IDLE;
                        m_pend = 1'b0;
                    end
                end
                M_IDLE: if (bus.LOAD_START) begin m_mode = M_LOAD; prog.delete(); end
                M_LOAD: begin
                    if (bus.LOAD_START) begin
                        m_mode = M_CLEAR; m_left = DEPTH; m_pend = 1'b1; prog.delete();
                    end else if (bus.LOAD_VALID) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        if (bus.LOAD_LAST) begin
                            s = int'(bus.LOAD_DATA);
                            foreach (prog[i]) s += int'(prog[i]);
                            m_err  = (s % 256) != 0;
                            m_mode = m_err ? M_IDLE : M_RUN;
                        end else begin
                            prog.push_back(bus.LOAD_DATA);
                            if (prog.size() == DEPTH) begin m_mode = M_IDLE; m_err = 1'b1; end
                        end
`else
                        prog.push_back(bus.LOAD_DATA);
                        if (bus.LOAD_LAST || prog.size() == DEPTH) m_mode = M_RUN;
`endif
                    end
                end
                default: if (bus.LOAD_START) begin
                    m_mode = M_CLEAR; m_left = DEPTH; m_pend = 1'b1; prog.delete();
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("cyc_load_ready", int'(bus.LOAD_READY), int'(m_mode == M_LOAD));
            chk("cyc_running",    int'(bus.RUNNING),    int'(m_mode == M_RUN));
            chk("cyc_cpu_hold",   int'(bus.CPU_HOLD),   int'(m_mode != M_RUN));
            chk("cyc_prog_len",   int'(bus.PROG_LEN),   prog.size());
            chk("cyc_err",        int'(bus.ERR),        int'(m_err));
            chk("cyc_instr",      int'(bus.INSTR),      exp_instr(int'(bus.PC)));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = d; bus.LOAD_LAST = last;
        tick();
        bus.LOAD_VALID = 1'b0; bus.LOAD_LAST = 1'b0;
    endtask

    task automatic pc_chk(input logic [7:0] pc, input int exp);
        tick();
        bus.PC = pc;
        #1;
        chk("instr_at_pc", int'(bus.INSTR), exp);
    endtask

    // From LOAD or RUN: restart, sweep through CLEAR, land in LOAD.
    task automatic restart();
        bus.LOAD_START = 1'b1;
        tick();
        bus.LOAD_START = 1'b0;
        chk("hold_after_restart", int'(bus.CPU_HOLD), 1);
        repeat (DEPTH - 1) tick();
        chk("ready_before_clear_end", int'(bus.LOAD_READY), 0);
        tick();
        chk("ready_after_clear", int'(bus.LOAD_READY), 1);
    endtask

    logic [7:0] stall_dat [6];
    bit         stall_vld [6];

    initial begin
        bus.LOAD_START = 1'b0; bus.LOAD_VALID = 1'b0; bus.LOAD_DATA = 8'h00;
        bus.LOAD_LAST = 1'b0; bus.PC = 8'h00;
        RST = 1'b1;
        #1 RST = 1'b0;
        #1;
        started = 1'b1;
        chk("rst_hold", int'(bus.CPU_HOLD), 1);
        chk("rst_len", int'(bus.PROG_LEN), 0);
        chk("rst_ready", int'(bus.LOAD_READY), 0);
        @(posedge CLK);
        #3 RST = 1'b1;
        repeat (DEPTH) tick();
        pc_chk(8'h00, 0); pc_chk(8'h05, 0); pc_chk(8'h0F, 0); pc_chk(8'hFF, 0);
        chk("idle_hold", int'(bus.CPU_HOLD), 1);
        chk("idle_len", int'(bus.PROG_LEN), 0);

        bus.LOAD_START = 1'b1; tick(); bus.LOAD_START = 1'b0;
        chk("load_ready", int'(bus.LOAD_READY), 1);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'hFD, 1'b1);
        chk("cs_ok_run", int'(bus.RUNNING), 1);
        chk("cs_ok_err", int'(bus.ERR), 0);
        chk("cs_ok_len", int'(bus.PROG_LEN), 2);
        pc_chk(8'h00, 8'h01); pc_chk(8'h01, 8'h02); pc_chk(8'h02, 8'h00);
        restart();
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'hFC, 1'b1);
        chk("cs_bad_err", int'(bus.ERR), 1);
        chk("cs_bad_run", int'(bus.RUNNING), 0);
        chk("cs_bad_hold", int'(bus.CPU_HOLD), 1);
        chk("cs_bad_ready", int'(bus.LOAD_READY), 0);
        bus.LOAD_START = 1'b1; tick(); bus.LOAD_START = 1'b0;
        chk("cs_err_clear", int'(bus.ERR), 0);
`else
        send(8'h41, 1'b0); send(8'h85, 1'b0); send(8'hC1, 1'b1);
        chk("p1_len", int'(bus.PROG_LEN), 3);
        chk("p1_run", int'(bus.RUNNING), 1);
        chk("p1_hold", int'(bus.CPU_HOLD), 0);
        pc_chk(8'h00, 8'h41); pc_chk(8'h01, 8'h85); pc_chk(8'h02, 8'hC1); pc_chk(8'h03, 8'h00);

        restart();
        for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i), 1'b0);
        chk("full_run", int'(bus.RUNNING), 1);
        chk("full_len", int'(bus.PROG_LEN), 16);
        send(8'h99, 1'b1);
        chk("extra_ignored_len", int'(bus.PROG_LEN), 16);
        pc_chk(8'h12, 8'h00); pc_chk(8'h0F, 8'h1F); pc_chk(8'h00, 8'h10); pc_chk(8'h07, 8'h17);

        restart();
        stall_vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        stall_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 6; i++) begin
            bus.LOAD_VALID = stall_vld[i];
            bus.LOAD_DATA  = stall_dat[i];
            bus.LOAD_LAST  = (i == 3 || i == 5);
            tick();
        end
        bus.LOAD_VALID = 1'b0; bus.LOAD_LAST = 1'b0;
        chk("stall_len", int'(bus.PROG_LEN), 3);
        pc_chk(8'h00, 8'hA0); pc_chk(8'h01, 8'hA2); pc_chk(8'h02, 8'hA5); pc_chk(8'h03, 8'h00);

        restart();
        bus.LOAD_START = 1'b1; bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = 8'h77;
        tick();
        bus.LOAD_START = 1'b0; bus.LOAD_VALID = 1'b0;
        chk("restart_wins_ready", int'(bus.LOAD_READY), 0);
        chk("restart_wins_len", int'(bus.PROG_LEN), 0);
        repeat (DEPTH) tick();
        send(8'h3C, 1'b1);
        chk("p3c_len", int'(bus.PROG_LEN), 1);
        pc_chk(8'h00, 8'h3C); pc_chk(8'h01, 8'h00); pc_chk(8'h0F, 8'h00);
        restart();
`endif
        bus.PC = 8'h00;
        send(8'h55, 1'b0); send(8'h66, 1'b0);
        chk("pre_rst_len", int'(bus.PROG_LEN), 2);
        #1 RST = 1'b0;
        #1;
        chk("async_rst_ready", int'(bus.LOAD_READY), 0);
        chk("async_rst_hold", int'(bus.CPU_HOLD), 1);
        chk("async_rst_len", int'(bus.PROG_LEN), 0);
        chk("async_rst_run", int'(bus.RUNNING), 0);
        chk("async_rst_err", int'(bus.ERR), 0);
        chk("async_rst_instr", int'(bus.INSTR), 0);
        repeat (2) tick();
        #1 RST = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("post_rst_idle_ready", int'(bus.LOAD_READY), 0);
        chk("post_rst_idle_len", int'(bus.PROG_LEN), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
